pipe_stage_skid: RTL and testbench

- Parametrised successor to the single-register pipeline latch used between snake-pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a one-entry skid buffer, so back-pressure does not need a combinational ready path across stages.
- Keeps the legacy global write_enable (stall) and flush controls.
- Payload width and flush semantics are configurable per stage.

---
 rtl/pipe_stage_skid.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer, global stall and flush.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned WIDTH                 = 181,
  parameter bit          CLEAR_DATA            = 1'b1,
  parameter bit          FLUSH_OVERRIDES_STALL = 1'b1,
  parameter int unsigned CNT_WIDTH             = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 write_enable,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

  if (WIDTH == 0 || CNT_WIDTH == 0) begin : g_bad_params
    $error("pipe_stage_skid: WIDTH and CNT_WIDTH must be non-zero");
  end

  logic             r_m_valid;
  logic             r_s_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;

  logic             w_acc;
  logic             w_drn;
  logic             w_flush_eff;
  logic             w_m_valid_nxt;
  logic             w_s_valid_nxt;
  logic [WIDTH-1:0] w_m_data_nxt;
  logic [WIDTH-1:0] w_s_data_nxt;

  assign w_acc       = in_valid & r_in_ready & write_enable;
  assign w_drn       = r_m_valid & out_ready & write_enable;
  assign w_flush_eff = flush & (FLUSH_OVERRIDES_STALL | write_enable);

  // Next-state selection for the main and skid entries; the skid only fills while main is blocked.
  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    w_m_data_nxt  = r_m_data;
    w_s_data_nxt  = r_s_data;
    if (w_flush_eff) begin
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
      if (CLEAR_DATA) begin
        w_m_data_nxt = {WIDTH{1'b0}};
        w_s_data_nxt = {WIDTH{1'b0}};
      end else begin
        w_m_data_nxt = r_m_data;
        w_s_data_nxt = r_s_data;
      end
    end else if (write_enable) begin
      if (!r_m_valid) begin
        if (w_acc) begin
          w_m_valid_nxt = 1'b1;
          w_m_data_nxt  = in_data;
        end else begin
          w_m_valid_nxt = 1'b0;
        end
      end else if (w_drn) begin
        if (r_s_valid) begin
          w_m_data_nxt  = r_s_data;
          w_s_valid_nxt = 1'b0;
        end else if (w_acc) begin
          w_m_data_nxt  = in_data;
        end else begin
          w_m_valid_nxt = 1'b0;
        end
      end else if (w_acc) begin
        w_s_valid_nxt = 1'b1;
        w_s_data_nxt  = in_data;
      end else begin
        w_m_valid_nxt = r_m_valid;
      end
    end else begin
      w_m_valid_nxt = r_m_valid;
    end
  end

  // State registers; in_ready is kept as its own flop so no output has logic after a register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_m_data   <= {WIDTH{1'b0}};
      r_s_data   <= {WIDTH{1'b0}};
    end else begin
      r_m_valid  <= w_m_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= ~w_s_valid_nxt;
      r_m_data   <= w_m_data_nxt;
      r_s_data   <= w_s_data_nxt;
    end
  end

  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign in_ready  = r_in_ready;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic                 w_stall_ev;

  assign w_stall_ev = r_m_valid & (~out_ready | ~write_enable);

  // Saturating event counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
      r_flush_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_stall_ev && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_flush_eff && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: default instance plus a legacy-flush instance sharing stimulus.
module tb_pipe_stage_skid;
  localparam int W  = 181;
  localparam int CW = 16;

  logic          Clk;
  logic          Rst_n;
  logic          write_enable;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          b_in_ready;
  logic          b_out_valid;
  logic [W-1:0]  b_out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] b_stall_cnt;
  logic [CW-1:0] b_flush_cnt;
  logic [CW-1:0] base_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_skid #(.WIDTH(W), .CLEAR_DATA(1'b1), .FLUSH_OVERRIDES_STALL(1'b1), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .write_enable(write_enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_skid #(.WIDTH(W), .CLEAR_DATA(1'b0), .FLUSH_OVERRIDES_STALL(1'b0), .CNT_WIDTH(CW)) dut_legacy (
    .Clk(Clk), .Rst_n(Rst_n), .write_enable(write_enable), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] mk(input logic [63:0] v);
    return {v[52:0], v, v};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on drain of the default instance.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else if (write_enable) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_data: got %0h expected %0h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // Skid entry occupied (in_ready low) must imply main entry occupied.
  always @(negedge Clk) begin
    if (Rst_n) begin
      checks++;
      assert (in_ready || out_valid) else begin
        errors++;
        $display("FAIL invariant_a: got in_ready=%0b out_valid=%0b expected out_valid=1", in_ready, out_valid);
      end
      assert (b_in_ready || b_out_valid) else begin
        errors++;
        $display("FAIL invariant_b: got in_ready=%0b out_valid=%0b expected out_valid=1", b_in_ready, b_out_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst_n = 1'b0; write_enable = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("reset_out_valid", W'(out_valid), W'(1'b0));
    chk("reset_in_ready", W'(in_ready), W'(1'b1));
    chk("reset_out_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    chk("reset_stall_cnt", W'(stall_cnt), '0);
    chk("reset_flush_cnt", W'(flush_cnt), '0);
`endif
    Rst_n = 1'b1;
    write_enable = 1'b1;

    // Streaming 1..8
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = mk(64'(i));
      step();
      chk("stream_out_valid", W'(out_valid), W'(1'b1));
      chk("stream_latency", out_data, mk(64'(i)));
      chk("stream_in_ready", W'(in_ready), W'(1'b1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", W'(out_valid), W'(1'b0));

    // Back-pressure A5 / B6
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(64'hA5);
    step();
    chk("bp_in_ready_a", W'(in_ready), W'(1'b1));
    in_data = mk(64'hB6);
    step();
    chk("bp_in_ready_b", W'(in_ready), W'(1'b0));
    chk("bp_head_a", out_data, mk(64'hA5));
    in_valid = 1'b0; in_data = mk(64'hFF);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_data, mk(64'hB6));
    chk("bp_in_ready_back", W'(in_ready), W'(1'b1));
    step();
    chk("bp_empty", W'(out_valid), W'(1'b0));
    chk("bp_in_ready_end", W'(in_ready), W'(1'b1));

    // Stall with 0x33 held
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(64'h33);
    step();
`ifdef PIPE_STAGE_PERF_EN
    base_cnt = stall_cnt;
`endif
    write_enable = 1'b0; in_data = mk(64'h44); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out_data", out_data, mk(64'h33));
      chk("stall_out_valid", W'(out_valid), W'(1'b1));
      chk("stall_in_ready", W'(in_ready), W'(1'b1));
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt_delta", W'(stall_cnt - base_cnt), W'(3));
`endif
    write_enable = 1'b1; in_valid = 1'b0;
    step();
    chk("stall_drained", W'(out_valid), W'(1'b0));

    // Flush: default overrides stall, legacy instance ignores it
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(64'h11);
    step();
    in_data = mk(64'h22);
    step();
    chk("flush_full", W'(in_ready), W'(1'b0));
`ifdef PIPE_STAGE_PERF_EN
    base_cnt = flush_cnt;
`endif
    in_valid = 1'b0; write_enable = 1'b0; flush = 1'b1;
    step();
    chk("flush_out_valid", W'(out_valid), W'(1'b0));
    chk("flush_out_data", out_data, '0);
    chk("flush_in_ready", W'(in_ready), W'(1'b1));
    chk("legacy_hold_valid", W'(b_out_valid), W'(1'b1));
    chk("legacy_hold_data", b_out_data, mk(64'h11));
    chk("legacy_hold_in_ready", W'(b_in_ready), W'(1'b0));
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt_one", W'(flush_cnt - base_cnt), W'(1));
`endif
    write_enable = 1'b1;
    step();
    chk("legacy_flush_valid", W'(b_out_valid), W'(1'b0));
    chk("legacy_flush_in_ready", W'(b_in_ready), W'(1'b1));
    chk("legacy_flush_data", b_out_data, mk(64'h11));
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt_two", W'(flush_cnt - base_cnt), W'(2));
`endif
    flush = 1'b0;

    // Asynchronous reset mid-cycle with both entries full
    in_valid = 1'b1; in_data = mk(64'h77);
    step();
    in_data = mk(64'h88);
    step();
    in_valid = 1'b0;
    chk("pre_reset_full", W'(in_ready), W'(1'b0));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), W'(1'b0));
    chk("async_in_ready", W'(in_ready), W'(1'b1));
    chk("async_out_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    chk("async_stall_cnt", W'(stall_cnt), '0);
    chk("async_flush_cnt", W'(flush_cnt), '0);
`endif
    step(); step();
    Rst_n = 1'b1;

    // Mixed back-pressure stream, checked by the scoreboard
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = mk(64'h100 + 64'(i));
      out_ready = (i % 3) != 0;
      step();
      while (!in_ready) begin
        out_ready = 1'b1;
        step();
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("final_empty", W'(out_valid), W'(1'b0));
    chk("final_queue", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
